// File: rtl/dcache_wt.sv
// Direct-mapped write-through no-write-allocate data cache, 4-word lines; `DCACHE_STATS_EN adds hit/miss counters.
// Latency: read hit 0 cycles; read miss L+1 stall cycles; store stalls until mem_ready.
// Backpressure: proc_stall holds the core; mem_read/mem_write held stable until mem_ready.
module dcache_wt #(
  parameter int NUM_LINES = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         proc_read,
  input  logic         proc_write,
  input  logic [31:0]  proc_addr,
  input  logic [31:0]  proc_wdata,
  output logic [31:0]  proc_rdata,
  output logic         proc_stall,
  output logic         mem_read,
  output logic         mem_write,
  output logic [31:0]  mem_addr,
  output logic [31:0]  mem_wdata,
  input  logic [127:0] mem_rdata,
  input  logic         mem_ready
`ifdef DCACHE_STATS_EN
  ,
  output logic [15:0]  hit_cnt,
  output logic [15:0]  miss_cnt
`endif
);

  localparam int IDX_W = $clog2(NUM_LINES);
  localparam int TAG_W = 28 - IDX_W;

  typedef enum logic [1:0] {IDLE, REFILL, WRITE} state_t;

  state_t                 state;
  logic [NUM_LINES-1:0]   valid_q;
  logic [TAG_W-1:0]       tag_q  [NUM_LINES];
  logic [127:0]           data_q [NUM_LINES];

  logic [IDX_W-1:0] idx;
  logic [TAG_W-1:0] tag;
  logic [6:0]       word_lsb;
  logic             hit;
  logic [31:0]      word;
  logic             unused_addr_bits;

  assign idx              = proc_addr[4 +: IDX_W];
  assign tag              = proc_addr[31 -: TAG_W];
  assign word_lsb         = {proc_addr[3:2], 5'b0};
  assign hit              = valid_q[idx] && (tag_q[idx] == tag);
  assign word             = data_q[idx][word_lsb +: 32];
  assign unused_addr_bits = ^proc_addr[1:0];

  // Core and memory outputs are all forced low while reset is held.
  always_comb begin
    proc_rdata = '0;
    proc_stall = 1'b0;
    mem_read   = 1'b0;
    mem_write  = 1'b0;
    mem_addr   = '0;
    mem_wdata  = '0;
    if (!rst) begin
      proc_rdata = word;
      case (state)
        IDLE: proc_stall = proc_write || (proc_read && !hit);
        REFILL: begin
          proc_stall = 1'b1;
          mem_read   = 1'b1;
          mem_addr   = {proc_addr[31:4], 4'b0};
        end
        WRITE: begin
          proc_stall = !mem_ready;
          mem_write  = 1'b1;
          mem_addr   = {proc_addr[31:2], 2'b0};
          mem_wdata  = proc_wdata;
        end
        default: proc_stall = 1'b0;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      valid_q <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (proc_write)
            state <= WRITE;
          else if (proc_read && !hit)
            state <= REFILL;
        end
        REFILL: begin
          if (mem_ready) begin
            valid_q[idx] <= 1'b1;
            state        <= IDLE;
          end
        end
        WRITE: begin
          if (mem_ready)
            state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Tag/data arrays carry no reset so they can map onto plain storage.
  always_ff @(posedge clk) begin
    if (!rst && state == REFILL && mem_ready) begin
      tag_q[idx]  <= tag;
      data_q[idx] <= mem_rdata;
    end else if (!rst && state == WRITE && mem_ready && hit) begin
      data_q[idx][word_lsb +: 32] <= proc_wdata;
    end
  end

`ifdef DCACHE_STATS_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      hit_cnt  <= '0;
      miss_cnt <= '0;
    end else if (state == IDLE && proc_read && !proc_write) begin
      if (hit && hit_cnt != 16'hFFFF)
        hit_cnt <= hit_cnt + 16'd1;
      else if (!hit && miss_cnt != 16'hFFFF)
        miss_cnt <= miss_cnt + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_dcache_wt.sv
// Directed bench for dcache_wt: refill, hits, write-through, no-allocate, conflict, reset abort, read+write.
module tb_dcache_wt;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         proc_read = 1'b0;
  logic         proc_write = 1'b0;
  logic [31:0]  proc_addr = '0;
  logic [31:0]  proc_wdata = '0;
  logic [31:0]  proc_rdata;
  logic         proc_stall;
  logic         mem_read;
  logic         mem_write;
  logic [31:0]  mem_addr;
  logic [31:0]  mem_wdata;
  logic [127:0] mem_rdata = '0;
  logic         mem_ready = 1'b0;
`ifdef DCACHE_STATS_EN
  logic [15:0]  hit_cnt;
  logic [15:0]  miss_cnt;
`endif

  int checks = 0;
  int failures = 0;

  dcache_wt #(.NUM_LINES(8)) dut (
    .clk        (clk),
    .rst        (rst),
    .proc_read  (proc_read),
    .proc_write (proc_write),
    .proc_addr  (proc_addr),
    .proc_wdata (proc_wdata),
    .proc_rdata (proc_rdata),
    .proc_stall (proc_stall),
    .mem_read   (mem_read),
    .mem_write  (mem_write),
    .mem_addr   (mem_addr),
    .mem_wdata  (mem_wdata),
    .mem_rdata  (mem_rdata),
    .mem_ready  (mem_ready)
`ifdef DCACHE_STATS_EN
    ,
    .hit_cnt    (hit_cnt),
    .miss_cnt   (miss_cnt)
`endif
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  // Miss in IDLE, lat REFILL cycles with mem_ready in the last, then one hit cycle.
  task automatic read_miss(input logic [31:0] addr, input logic [127:0] line,
                           input int lat, input logic [31:0] expw);
    proc_read  = 1'b1;
    proc_write = 1'b0;
    proc_addr  = addr;
    settle();
    chk("miss_idle_stall", {31'b0, proc_stall}, 32'd1);
    chk("miss_idle_mem_read", {31'b0, mem_read}, 32'd0);
    for (int i = 1; i <= lat; i++) begin
      step();
      mem_ready = (i == lat);
      mem_rdata = line;
      settle();
      chk("refill_mem_read", {31'b0, mem_read}, 32'd1);
      chk("refill_addr", mem_addr, addr & 32'hFFFF_FFF0);
      chk("refill_stall", {31'b0, proc_stall}, 32'd1);
    end
    step();
    mem_ready = 1'b0;
    settle();
    chk("post_refill_stall", {31'b0, proc_stall}, 32'd0);
    chk("post_refill_rdata", proc_rdata, expw);
    step();
    proc_read = 1'b0;
  endtask

  initial begin
    // Reset held with a request present: everything must read zero.
    step();
    proc_read  = 1'b1;
    proc_write = 1'b1;
    proc_addr  = 32'h1234_5678;
    proc_wdata = 32'h0000_0055;
    step();
    settle();
    chk("rst_stall", {31'b0, proc_stall}, 32'd0);
    chk("rst_mem_read", {31'b0, mem_read}, 32'd0);
    chk("rst_mem_write", {31'b0, mem_write}, 32'd0);
    chk("rst_mem_addr", mem_addr, 32'd0);
    chk("rst_mem_wdata", mem_wdata, 32'd0);
    chk("rst_rdata", proc_rdata, 32'd0);
    rst        = 1'b0;
    proc_read  = 1'b0;
    proc_write = 1'b0;
    proc_wdata = '0;

    // Read miss with L=3 then repeat hit on the neighbouring word.
    read_miss(32'h1000_0010, 128'h00000044_00000033_00000022_00000011, 3, 32'h0000_0011);
    proc_read = 1'b1;
    proc_addr = 32'h1000_0014;
    settle();
    chk("hit_0x14_stall", {31'b0, proc_stall}, 32'd0);
    chk("hit_0x14_rdata", proc_rdata, 32'h0000_0022);
    step();
    proc_read = 1'b0;
    settle();
`ifdef DCACHE_STATS_EN
    chk("stats_miss_cnt", {16'b0, miss_cnt}, 32'd1);
    chk("stats_hit_cnt", {16'b0, hit_cnt}, 32'd2);
`endif

    // Store to a cached word, L=2.
    proc_write = 1'b1;
    proc_addr  = 32'h1000_0018;
    proc_wdata = 32'hDEAD_BEEF;
    settle();
    chk("st_idle_stall", {31'b0, proc_stall}, 32'd1);
    chk("st_idle_mem_write", {31'b0, mem_write}, 32'd0);
    step();
    settle();
    chk("st_w1_mem_write", {31'b0, mem_write}, 32'd1);
    chk("st_w1_addr", mem_addr, 32'h1000_0018);
    chk("st_w1_wdata", mem_wdata, 32'hDEAD_BEEF);
    chk("st_w1_stall", {31'b0, proc_stall}, 32'd1);
    step();
    mem_ready = 1'b1;
    settle();
    chk("st_w2_stall", {31'b0, proc_stall}, 32'd0);
    chk("st_w2_mem_write", {31'b0, mem_write}, 32'd1);
    step();
    mem_ready  = 1'b0;
    proc_write = 1'b0;
    proc_read  = 1'b1;
    settle();
    chk("st_readback_stall", {31'b0, proc_stall}, 32'd0);
    chk("st_readback_rdata", proc_rdata, 32'hDEAD_BEEF);
    chk("st_readback_mem_write", {31'b0, mem_write}, 32'd0);
    step();
    proc_addr = 32'h1000_001C;
    settle();
    chk("st_neighbour_rdata", proc_rdata, 32'h0000_0044);
    step();
    proc_read = 1'b0;

    // Store to an uncached line with L=1: no stall in WRITE, no allocate.
    proc_write = 1'b1;
    proc_addr  = 32'h1000_0040;
    proc_wdata = 32'h0BAD_F00D;
    settle();
    chk("nwa_idle_stall", {31'b0, proc_stall}, 32'd1);
    step();
    mem_ready = 1'b1;
    settle();
    chk("nwa_mem_write", {31'b0, mem_write}, 32'd1);
    chk("nwa_addr", mem_addr, 32'h1000_0040);
    chk("nwa_stall", {31'b0, proc_stall}, 32'd0);
    step();
    mem_ready  = 1'b0;
    proc_write = 1'b0;
    read_miss(32'h1000_0040, 128'h0000000D_0000000C_0000000B_000000A0, 1, 32'h0000_00A0);

    // Conflict on index 0: last refill wins.
    read_miss(32'h1000_0000, 128'h0000000B_0000000B_0000000B_000000B0, 1, 32'h0000_00B0);
    read_miss(32'h2000_0000, 128'h0000000C_0000000C_0000000C_000000C0, 2, 32'h0000_00C0);
    read_miss(32'h1000_0000, 128'h0000000B_0000000B_0000000B_000000B1, 1, 32'h0000_00B1);

    // Reset in the 2nd REFILL cycle, even with mem_ready high, writes nothing.
    proc_read = 1'b1;
    proc_addr = 32'h1000_0050;
    settle();
    chk("rr_idle_stall", {31'b0, proc_stall}, 32'd1);
    step();
    settle();
    chk("rr_r1_mem_read", {31'b0, mem_read}, 32'd1);
    step();
    rst       = 1'b1;
    mem_ready = 1'b1;
    mem_rdata = {4{32'hEEEE_EEEE}};
    settle();
    chk("rr_rst_mem_read", {31'b0, mem_read}, 32'd0);
    chk("rr_rst_stall", {31'b0, proc_stall}, 32'd0);
    step();
    rst       = 1'b0;
    mem_ready = 1'b0;
    settle();
`ifdef DCACHE_STATS_EN
    chk("rr_stats_miss_cnt", {16'b0, miss_cnt}, 32'd0);
    chk("rr_stats_hit_cnt", {16'b0, hit_cnt}, 32'd0);
`endif
    read_miss(32'h1000_0050, 128'h00000003_00000002_00000001_000000D0, 1, 32'h0000_00D0);

    // Read and write together: a write only.
    proc_read  = 1'b1;
    proc_write = 1'b1;
    proc_addr  = 32'h1000_0020;
    proc_wdata = 32'h0000_0077;
    settle();
    chk("rw_idle_stall", {31'b0, proc_stall}, 32'd1);
    chk("rw_idle_mem_read", {31'b0, mem_read}, 32'd0);
    step();
    mem_ready = 1'b1;
    settle();
    chk("rw_mem_write", {31'b0, mem_write}, 32'd1);
    chk("rw_mem_read", {31'b0, mem_read}, 32'd0);
    chk("rw_addr", mem_addr, 32'h1000_0020);
    chk("rw_wdata", mem_wdata, 32'h0000_0077);
    chk("rw_stall", {31'b0, proc_stall}, 32'd0);
    step();
    mem_ready  = 1'b0;
    proc_write = 1'b0;
    settle();
    chk("rw_after_stall", {31'b0, proc_stall}, 32'd1);
    chk("rw_after_mem_read", {31'b0, mem_read}, 32'd0);
    chk("rw_after_mem_write", {31'b0, mem_write}, 32'd0);
    proc_read = 1'b0;
    settle();
    chk("rw_idle_quiet_stall", {31'b0, proc_stall}, 32'd0);
    step();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
